// File: rtl/regfile_wb_if.sv
// Write-back bus: two completion sources (mem, alu) in, register-file write port out.
interface regfile_wb_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          wb_hold;
  logic          rf_load;
  logic [4:0]    rf_dest;
  logic [31:0]   rf_in;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  // Completion sources and write-port consumer
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, wb_hold,
    input  mem_ready, alu_ready, rf_load, rf_dest, rf_in, pending, count
  );

  // Write-back queue
  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, wb_hold,
    output mem_ready, alu_ready, rf_load, rf_dest, rf_in, pending, count
  );
endinterface

// File: rtl/regfile_wb.sv
// In-order write-back queue merging load and ALU completions into one
// register-file write port, with a per-register pending scoreboard.
module regfile_wb #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] occ;
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic        not_full, mem_fire, alu_fire, push, pop;
  logic [4:0]  enq_rd;
  logic [31:0] enq_data;
  logic [31:0] pending_c;

  // Ready ignores a same-cycle dequeue so it never depends on wb_hold.
  assign not_full      = count_q < CW'(DEPTH);
  assign bus.mem_ready = !rst && not_full;
  assign bus.alu_ready = !rst && not_full && !bus.mem_valid;

  assign mem_fire = bus.mem_valid && bus.mem_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign enq_rd   = mem_fire ? bus.mem_rd   : bus.alu_rd;
  assign enq_data = mem_fire ? bus.mem_data : bus.alu_data;
  // Writes to x0 complete the handshake but are never stored.
  assign push     = (mem_fire || alu_fire) && (enq_rd != 5'd0);

  // Head is only presented from registered state, so a new entry waits a cycle.
  assign bus.rf_load = !rst && (count_q != '0) && !bus.wb_hold;
  assign bus.rf_dest = (!rst && count_q != '0) ? rd_mem[head]   : 5'd0;
  assign bus.rf_in   = (!rst && count_q != '0) ? data_mem[head] : 32'd0;
  assign pop         = bus.rf_load;
  assign bus.count   = count_q;

  // Pointers, occupancy and count
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      occ     <= '0;
    end else begin
      if (push) begin
        occ[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        occ[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are qualified by occ so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= enq_rd;
      data_mem[tail] <= enq_data;
    end
  end

  // Pending scoreboard: OR of onehot(rd) over occupied entries.
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < DEPTH; i++)
      if (occ[i]) pending_c[rd_mem[i]] = 1'b1;
    pending_c[0] = 1'b0;
    if (rst) pending_c = '0;
  end

  assign bus.pending = pending_c;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: driver pushes expected writes, monitor pops on rf_load.
module tb_regfile_wb;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [36:0] exp_q [$];

  regfile_wb_if #(.DEPTH(DEPTH)) bus ();
  regfile_wb #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every register-file write must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rf_load === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: rd=%0d data=0x%08h with empty scoreboard",
                   bus.rf_dest, bus.rf_in);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if ({bus.rf_dest, bus.rf_in} !== e) begin
            failures++;
            $display("FAIL wb_data: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                     bus.rf_dest, bus.rf_in, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Single write of rd=5 through an empty queue, then drained.
  task automatic single_write();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'hDEADBEEF;
    settle();
    chk("single_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("single_no_passthru", 32'(bus.rf_load), 32'd0);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step(); idle(); settle();
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_rf_load", 32'(bus.rf_load), 32'd1);
    chk("single_pending", bus.pending, 32'h0000_0020);
    step(); settle();
    chk("single_pending_clear", bus.pending, 32'd0);
    chk("single_count_zero", 32'(bus.count), 32'd0);
    chk("single_idle", 32'(bus.rf_load), 32'd0);
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.wb_hold = 1'b0;

    // Reset state
    step(); step(); settle();
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_rf_load", 32'(bus.rf_load), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    step(); rst = 1'b0;

    single_write();

    // Priority: mem beats alu, alu follows next cycle.
    step();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
    settle();
    chk("prio_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("prio_alu_blocked", 32'(bus.alu_ready), 32'd0);
    exp_q.push_back({5'd3, 32'h11});
    step(); bus.mem_valid = 1'b0; settle();
    chk("prio_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("prio_x3_load", 32'(bus.rf_dest), 32'd3);
    exp_q.push_back({5'd4, 32'h22});
    step(); idle(); settle();
    chk("prio_x4_load", 32'(bus.rf_dest), 32'd4);
    chk("prio_count", 32'(bus.count), 32'd1);
    step(); settle();
    chk("prio_drained", 32'(bus.count), 32'd0);

    // Fill under hold: 5 offered, 4 accepted.
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(8 + i); bus.alu_data = 32'hA0 + 32'(i);
      settle();
      chk("fill_alu_ready", 32'(bus.alu_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back({5'(8 + i), 32'hA0 + 32'(i)});
      if (i < 4) step();
    end
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("fill_hold_no_load", 32'(bus.rf_load), 32'd0);
    chk("fill_pending", bus.pending, 32'h0000_0F00);
    step(); idle(); bus.wb_hold = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      chk("drain_load", 32'(bus.rf_load), 32'd1);
      step(); settle();
    end
    chk("drain_count", 32'(bus.count), 32'd0);

    // Same-register ordering on x7.
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h1;
    exp_q.push_back({5'd7, 32'h1});
    step(); bus.mem_data = 32'h2; settle();
    chk("same_pending_a", bus.pending, 32'h80);
    exp_q.push_back({5'd7, 32'h2});
    step(); idle(); settle();
    chk("same_pending_b", bus.pending, 32'h80);
    chk("same_second_data", bus.rf_in, 32'h2);
    step(); settle();
    chk("same_pending_clear", bus.pending, 32'd0);

    // x0 write is accepted but dropped.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
    settle();
    chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    step(); idle(); settle();
    chk("x0_count", 32'(bus.count), 32'd0);
    chk("x0_no_load", 32'(bus.rf_load), 32'd0);
    chk("x0_pending", bus.pending, 32'd0);

    // Reset mid-operation with 3 queued entries.
    bus.wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 32'(i);
      step();
    end
    idle(); settle();
    chk("mid_count", 32'(bus.count), 32'd3);
    rst = 1'b1; bus.wb_hold = 1'b0; exp_q.delete(); settle();
    chk("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("mid_rst_load", 32'(bus.rf_load), 32'd0);
    chk("mid_rst_pending", bus.pending, 32'd0);
    step(); rst = 1'b0; settle();
    chk("post_rst_count", 32'(bus.count), 32'd0);
    chk("post_rst_load", 32'(bus.rf_load), 32'd0);
    chk("post_rst_pending", bus.pending, 32'd0);
    single_write();

    step(); step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
